// File: rtl/uart_arith.sv
// Byte-stream arithmetic unit: opcode + two big-endian operands in, 2W-bit result out (MSB first).
// Optional inter-byte timeout in RX_A/RX_B is compiled in with `define UART_ARITH_TIMEOUT_EN.
module uart_arith #(
  parameter int OPERAND_BYTES  = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       busy_o,
  output logic       err_o
);

  localparam int W  = 8 * OPERAND_BYTES;
  localparam int BW = $clog2(W + 1);

  localparam logic [1:0] OP_MUL = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;

  // Handshake: a byte moves on rx when rx_valid_i && rx_ready_o, and on tx when
  // tx_valid_o && tx_ready_i, both sampled at the rising edge of clk.
  typedef enum logic [2:0] {IDLE, RX_A, RX_B, CALC, TX} state_t;

  state_t         state, state_nx;
  logic [1:0]     op;
  logic [W-1:0]   a;
  logic [2*W-1:0] acc;
  logic [3:0]     byte_cnt;
  logic [BW-1:0]  bit_cnt;
  logic           err_q;

  logic           rx_fire, tx_fire;
  logic           last_operand_byte, last_tx_byte, calc_done;
  logic           illegal_op, timeout;
  logic [W:0]     mul_sum;

  assign rx_fire           = rx_valid_i && rx_ready_o;
  assign tx_fire           = tx_valid_o && tx_ready_i;
  assign last_operand_byte = (byte_cnt == 4'(OPERAND_BYTES - 1));
  assign last_tx_byte      = (byte_cnt == 4'(2 * OPERAND_BYTES - 1));
  assign calc_done         = (op != OP_MUL) || (bit_cnt == BW'(W - 1));
  assign illegal_op        = (state == IDLE) && rx_fire && (rx_data_i > 8'h02);

  // During MUL the low half of acc holds the not-yet-consumed multiplier bits.
  assign mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, a} : '0);

`ifdef UART_ARITH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  assign timeout = ((state == RX_A) || (state == RX_B)) && !rx_fire &&
                   (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (((state == RX_A) || (state == RX_B)) && !rx_fire && !timeout) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (rx_fire && (rx_data_i <= 8'h02)) state_nx = RX_A;
      RX_A: begin
        if (timeout)                             state_nx = IDLE;
        else if (rx_fire && last_operand_byte)   state_nx = RX_B;
      end
      RX_B: begin
        if (timeout)                             state_nx = IDLE;
        else if (rx_fire && last_operand_byte)   state_nx = CALC;
      end
      CALC: if (calc_done)                       state_nx = TX;
      TX:   if (tx_fire && last_tx_byte)         state_nx = IDLE;
      default:                                   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op       <= OP_MUL;
      a        <= '0;
      acc      <= '0;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= illegal_op || timeout;
      case (state)
        IDLE: begin
          byte_cnt <= '0;
          bit_cnt  <= '0;
          if (rx_fire) begin
            op  <= rx_data_i[1:0];
            a   <= '0;
            acc <= '0;
          end
        end
        RX_A, RX_B: begin
          if (timeout) begin
            byte_cnt <= '0;
          end else if (rx_fire) begin
            // B is shifted straight into the low half of acc, ready for CALC.
            if (state == RX_A) a   <= (a << 8) | W'(rx_data_i);
            else               acc <= (acc << 8) | (2*W)'(rx_data_i);
            byte_cnt <= last_operand_byte ? 4'd0 : byte_cnt + 4'd1;
          end
        end
        CALC: begin
          case (op)
            OP_MUL: begin
              acc     <= {mul_sum, acc[W-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
            end
            OP_ADD:  acc <= {{W{1'b0}}, a} + {{W{1'b0}}, acc[W-1:0]};
            OP_SUB:  acc <= {{W{1'b0}}, a} - {{W{1'b0}}, acc[W-1:0]};
            default: acc <= acc;
          endcase
        end
        TX: begin
          if (tx_fire) begin
            acc      <= acc << 8;
            byte_cnt <= byte_cnt + 4'd1;
          end
        end
        default: byte_cnt <= '0;
      endcase
    end
  end

  // rx_ready_o is masked by rst so it reads 0 for the whole reset pulse.
  assign rx_ready_o = !rst && ((state == IDLE) || (state == RX_A) || (state == RX_B));
  assign tx_valid_o = (state == TX);
  assign tx_data_o  = tx_valid_o ? acc[2*W-1 -: 8] : 8'h00;
  assign busy_o     = (state != IDLE);
  assign err_o      = err_q;

endmodule

// File: tb/tb_uart_arith.sv
// Scoreboard bench for uart_arith: random and directed frames against an arithmetic reference.
// Timeout behaviour is checked in whichever form UART_ARITH_TIMEOUT_EN selects.
module tb_uart_arith;

  localparam int OB = 4;
  localparam int W  = 8 * OB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       rx_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic       busy_o;
  logic       err_o;

  int total = 0;
  int bad   = 0;
  logic bp_en = 1'b0;
  logic [7:0] exp_q[$];

  uart_arith #(.OPERAND_BYTES(OB), .TIMEOUT_CYCLES(50)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checker helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: plain arithmetic on 2W-bit values, no datapath detail.
  function automatic logic [63:0] ref_result(input logic [7:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [63:0] aa, bb;
    aa = 64'(a);
    bb = 64'(b);
    case (op)
      8'h00:   return aa * bb;
      8'h01:   return aa + bb;
      default: return aa - bb;
    endcase
  endfunction

  task automatic push_expected(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] r;
    r = ref_result(op, a, b);
    for (int i = 2 * OB - 1; i >= 0; i--) exp_q.push_back(r[8*i +: 8]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    n = 0;
    while (!rx_ready_o && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) check("rx_accept_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_operand(input logic [W-1:0] v);
    for (int i = OB - 1; i >= 0; i--) send_byte(v[8*i +: 8]);
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit push);
    send_byte(op);
    send_operand(a);
    send_operand(b);
    if (push) push_expected(op, a, b);
  endtask

  task automatic measure_latency(output int lat);
    int n;
    n = 0;
    while (!tx_valid_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n + 1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) check("wait_idle_timeout", 64'(n), 64'd0);
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(0, 255));
      default: return W'($urandom);
    endcase
  endfunction

  // tx_ready_i is either held high or toggled randomly each cycle.
  always @(posedge clk) begin
    #1;
    tx_ready_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  logic [7:0] held;
  logic       stalled = 1'b0;
  logic       chk_after = 1'b0;
  int         tx_idx = 0;

  always @(negedge clk) begin
    if (rst) begin
      stalled   = 1'b0;
      chk_after = 1'b0;
      tx_idx    = 0;
    end else begin
      if (chk_after) begin
        check("rx_ready_after_last_tx", 64'(rx_ready_o), 64'd1);
        check("tx_valid_drop", 64'(tx_valid_o), 64'd0);
        chk_after = 1'b0;
      end
      if (stalled) begin
        check("tx_hold_valid", 64'(tx_valid_o), 64'd1);
        check("tx_hold_data", 64'(tx_data_o), 64'(held));
      end
      if (tx_valid_o && tx_ready_i) begin
        if (exp_q.size() == 0) begin
          check("tx_unexpected_byte", 64'(tx_data_o), 64'hdead);
        end else begin
          check("tx_byte", 64'(tx_data_o), 64'(exp_q.pop_front()));
        end
        tx_idx++;
        if (tx_idx == 2 * OB) begin
          tx_idx    = 0;
          chk_after = 1'b1;
        end
        stalled = 1'b0;
      end else begin
        stalled = tx_valid_o;
        held    = tx_data_o;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int n;
    logic [W-1:0] a, b;

    rst        = 1'b1;
    rx_data_i  = 8'h00;
    rx_valid_i = 1'b0;
    tx_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_ready", 64'(rx_ready_o), 64'd0);
    check("reset_tx_valid", 64'(tx_valid_o), 64'd0);
    check("reset_tx_data", 64'(tx_data_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_err", 64'(err_o), 64'd0);
    rst = 1'b0;
    #1;
    check("release_rx_ready", 64'(rx_ready_o), 64'd1);
    @(posedge clk); #1;

    // MUL 2*4 with latency W+1
    send_frame(8'h00, 32'h0000_0002, 32'h0000_0004, 1'b1);
    measure_latency(lat);
    check("mul_latency", 64'(lat), 64'(W + 1));
    wait_idle();

    // MUL max operands
    send_frame(8'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_idle();

    // ADD carry-out, latency 2
    send_frame(8'h01, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    measure_latency(lat);
    check("add_latency", 64'(lat), 64'd2);
    wait_idle();

    // SUB with B > A
    send_frame(8'h02, 32'h0000_0001, 32'h0000_0002, 1'b1);
    measure_latency(lat);
    check("sub_latency", 64'(lat), 64'd2);
    wait_idle();

    // Illegal opcode then a backpressured MUL
    send_byte(8'h07);
    check("illegal_err_pulse", 64'(err_o), 64'd1);
    check("illegal_busy", 64'(busy_o), 64'd0);
    @(posedge clk); #1;
    check("illegal_err_clear", 64'(err_o), 64'd0);
    check("illegal_busy_after", 64'(busy_o), 64'd0);
    bp_en = 1'b1;
    send_frame(8'h00, W'($urandom), W'($urandom), 1'b1);
    wait_idle();
    bp_en = 1'b0;

    // Reset in the middle of MUL CALC
    send_frame(8'h00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("calc_busy", 64'(busy_o), 64'd1);
    rst = 1'b1;
    #1;
    check("midcalc_rst_busy", 64'(busy_o), 64'd0);
    check("midcalc_rst_tx_valid", 64'(tx_valid_o), 64'd0);
    check("midcalc_rst_tx_data", 64'(tx_data_o), 64'd0);
    check("midcalc_rst_rx_ready", 64'(rx_ready_o), 64'd0);
    check("midcalc_rst_err", 64'(err_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midcalc_release_rx_ready", 64'(rx_ready_o), 64'd1);
    repeat (40) @(posedge clk);
    #1;
    send_frame(8'h00, 32'h0001_0003, 32'h0000_0101, 1'b1);
    wait_idle();

    // Inter-byte gap
`ifdef UART_ARITH_TIMEOUT_EN
    send_byte(8'h00);
    send_byte(8'h12);
    n = 0;
    while (!err_o && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("timeout_cycles", 64'(n), 64'd50);
    check("timeout_idle", 64'(busy_o), 64'd0);
    @(posedge clk); #1;
    check("timeout_err_clear", 64'(err_o), 64'd0);
    send_frame(8'h01, 32'h0000_00FF, 32'h0000_0001, 1'b1);
    wait_idle();
`else
    a = {8'h12, 24'($urandom)};
    b = W'($urandom);
    send_byte(8'h00);
    send_byte(a[31:24]);
    repeat (60) @(posedge clk);
    #1;
    check("gap_still_busy", 64'(busy_o), 64'd1);
    check("gap_no_err", 64'(err_o), 64'd0);
    for (int i = 2; i >= 0; i--) send_byte(a[8*i +: 8]);
    send_operand(b);
    push_expected(8'h00, a, b);
    wait_idle();
`endif

    // Random back-to-back frames
    for (int f = 0; f < 24; f++) begin
      bp_en = 1'($urandom_range(0, 1));
      a = rand_operand();
      b = rand_operand();
      send_frame(8'($urandom_range(0, 2)), a, b, 1'b1);
    end
    wait_idle();
    bp_en = 1'b0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
